// File: rtl/axis_mux_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter/mux.
// Holds select-code constants, FSM states and the rotating search.
package axis_mux_pkg;

  localparam int SEL_EN_BIT = 7;
  localparam logic [7:0] NO_SEL = 8'h00;
  localparam int MAX_CH = 64;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // First set bit strictly after ptr, wrapping; {hit, idx}.
  function automatic logic [6:0] rr_first(
    input logic [MAX_CH-1:0] req,
    input int n,
    input int ptr
  );
    logic [6:0] r;
    int c;
    r = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      c = ptr + k;
      if (c >= n) c = c - n;
      if (k <= n && !r[6] && req[c[5:0]])
        r = {1'b1, c[5:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_pkt_arb_mux_if.sv
// Bundled AXI-Stream lanes; N lanes packed side by side.
// master drives payload, slave returns tready.
interface axis_pkt_arb_mux_if #(
  parameter int N = 1,
  parameter int DATA_W = 32
);
  localparam int KEEP_W = DATA_W / 8;

  logic [N-1:0]        tvalid;
  logic [N-1:0]        tready;
  logic [N*DATA_W-1:0] tdata;
  logic [N*KEEP_W-1:0] tkeep;
  logic [N-1:0]        tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );

endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin pick: first requester after ptr, with wrap.
// Purely combinational; caller owns the pointer register.
module axis_rr_arbiter
  import axis_mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [MAX_CH-1:0] req_w;
  logic [6:0]        pick;

  always_comb begin
    req_w = '0;
    req_w[NUM_CH-1:0] = req;
    pick = rr_first(req_w, NUM_CH, int'(ptr));
    gnt_vld = pick[6];
    gnt_idx = IDX_W'(pick[5:0]);
  end

endmodule

// File: rtl/axis_pkt_arb_mux.sv
// N-to-1 AXI-Stream packet mux with registered output,
// packet-atomic switching and software or round-robin grant.
module axis_pkt_arb_mux
  import axis_mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int ARB_MODE = 0,
  parameter int SEL_W = 8,
  localparam int KEEP_W = DATA_W / 8,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [SEL_W-1:0]  bus_sel,
  axis_pkt_arb_mux_if.slave  s_axis,
  axis_pkt_arb_mux_if.master m_axis,
  output logic [IDX_W-1:0]  cur_grant,
  output logic              pkt_active
);

  state_e state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic [2**IDX_W-1:0]   req_ext;
  logic [SEL_W-2:0]      sel_idx;
  logic                  sel_ok;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  cin_vld;
  logic [DATA_W-1:0]     cin_data;
  logic [KEEP_W-1:0]     cin_keep;
  logic                  cin_last;
  logic                  busy;
  logic                  in_rdy;
  logic                  in_hs;
  logic [NUM_CH-1:0]     rdy;

  axis_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req    (s_axis.tvalid),
    .ptr    (rr_q),
    .gnt_idx(arb_idx),
    .gnt_vld(arb_vld)
  );

  always_comb begin
    req_ext = '0;
    req_ext[NUM_CH-1:0] = s_axis.tvalid;
    sel_idx = bus_sel[SEL_W-2:0];
    sel_ok = bus_sel[SEL_W-1]
          && (32'(sel_idx) < NUM_CH)
          && req_ext[IDX_W'(sel_idx)];
    if (ARB_MODE == 1) begin
      pick_vld = arb_vld;
      pick_idx = arb_idx;
    end else begin
      pick_vld = sel_ok;
      pick_idx = IDX_W'(sel_idx);
    end
  end

  always_comb begin
    cin_vld  = 1'b0;
    cin_data = '0;
    cin_keep = '0;
    cin_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        cin_vld  = s_axis.tvalid[i];
        cin_data = s_axis.tdata[i*DATA_W +: DATA_W];
        cin_keep = s_axis.tkeep[i*KEEP_W +: KEEP_W];
        cin_last = s_axis.tlast[i];
      end
    end
  end

  always_comb begin
    busy   = (state_q == BUSY);
    in_rdy = !mvalid_q || m_axis.tready[0];
    in_hs  = busy && in_rdy && cin_vld;
    rdy    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q == IDX_W'(i)) rdy[i] = busy && in_rdy;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    mvalid_d = mvalid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    if (mvalid_q && m_axis.tready[0]) mvalid_d = 1'b0;
    if (in_hs) begin
      mvalid_d = 1'b1;
      data_d   = cin_data;
      keep_d   = cin_keep;
      last_d   = cin_last;
    end
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
        end
      end
      BUSY: begin
        // last input beat ends the packet; pointer follows the winner
        if (in_hs && cin_last) begin
          state_d = IDLE;
          if (ARB_MODE == 1) rr_d = gnt_q;
        end
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      mvalid_q <= 1'b0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      mvalid_q <= mvalid_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
    end
  end

  assign s_axis.tready = rdy;
  assign m_axis.tvalid = mvalid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;
  assign cur_grant     = gnt_q;
  assign pkt_active    = busy;

endmodule
